mdu_seq: RTL and testbench

MDU_SEQ -- requirements
Module: mdu_seq

---
 rtl/mdu_seq_if.sv | 30 +++
 rtl/mdu_seq.sv | 174 +++++++++++++++++
 tb/tb_mdu_seq.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mdu_seq_if.sv
// Request/response bundle between the execute stage and the sequential RV32M unit.
// The slave modport is the unit side; master is the pipeline side.
interface mdu_seq_if #(
    parameter int XLEN = 32
);
    // Handshake rule: a transfer happens on a rising edge where valid and ready are both
    // high; valid never waits for ready, and payload is stable while valid is high.
    logic            req_valid;
    logic            req_ready;
    logic [2:0]      req_funct;
    logic [XLEN-1:0] req_a;
    logic [XLEN-1:0] req_b;
    logic [4:0]      req_rd;
    logic            resp_valid;
    logic            resp_ready;
    logic [XLEN-1:0] resp_result;
    logic [4:0]      resp_rd;
    logic            kill;
    logic            busy;

    modport slave (
        input  req_valid, req_funct, req_a, req_b, req_rd, resp_ready, kill,
        output req_ready, resp_valid, resp_result, resp_rd, busy
    );

    modport master (
        output req_valid, req_funct, req_a, req_b, req_rd, resp_ready, kill,
        input  req_ready, resp_valid, resp_result, resp_rd, busy
    );
endinterface

// File: rtl/mdu_seq.sv
// Sequential RV32M multiply/divide unit: one radix-2 step per cycle, IDLE/BUSY/DONE FSM.
// Optional MDU_FAST_SPECIAL_EN finishes zero-divisor, signed-overflow and zero-multiply ops at accept.
module mdu_seq #(
    parameter int XLEN = 32
) (
    input  logic                      clk,
    input  logic                      reset,
    mdu_seq_if.slave                  bus,
    output logic [1:0]                o_dbg_state,
    output logic [$clog2(XLEN)-1:0]   o_dbg_count
);
    localparam int CW = $clog2(XLEN);
    localparam logic [XLEN-1:0] ONES = '1;
    localparam logic [XLEN-1:0] MIN  = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [CW-1:0]       r_count;
    logic [2:0]          r_funct;
    logic [4:0]          r_rd;
    logic [XLEN-1:0]     r_b;
    logic [2*XLEN-1:0]   r_acc;
    logic                r_neg_q;
    logic                r_neg_r;
    logic [XLEN-1:0]     r_result;

    logic                w_accept;
    logic                w_last;
    logic                w_a_signed;
    logic                w_b_signed;
    logic                w_a_neg;
    logic                w_b_neg;
    logic [XLEN-1:0]     w_a_mag;
    logic [XLEN-1:0]     w_b_mag;
    logic                w_b_zero;
    logic                w_fast;
    logic [XLEN-1:0]     w_fast_res;

    assign w_accept   = (r_state == S_IDLE) && bus.req_valid && !bus.kill;
    assign w_last     = (r_count == CW'(XLEN - 1));
    assign w_a_signed = (bus.req_funct == 3'd1) || (bus.req_funct == 3'd2) ||
                        (bus.req_funct == 3'd4) || (bus.req_funct == 3'd6);
    assign w_b_signed = (bus.req_funct == 3'd1) || (bus.req_funct == 3'd4) ||
                        (bus.req_funct == 3'd6);
    assign w_a_neg    = w_a_signed && bus.req_a[XLEN-1];
    assign w_b_neg    = w_b_signed && bus.req_b[XLEN-1];
    assign w_a_mag    = w_a_neg ? (ONES - bus.req_a + 1'b1) : bus.req_a;
    assign w_b_mag    = w_b_neg ? (ONES - bus.req_b + 1'b1) : bus.req_b;
    assign w_b_zero   = (bus.req_b == '0);

`ifdef MDU_FAST_SPECIAL_EN
    logic w_divz;
    logic w_ovf;
    logic w_mulz;

    assign w_divz = bus.req_funct[2] && w_b_zero;
    assign w_ovf  = ((bus.req_funct == 3'd4) || (bus.req_funct == 3'd6)) &&
                    (bus.req_a == MIN) && (bus.req_b == ONES);
    assign w_mulz = !bus.req_funct[2] && ((bus.req_a == '0) || w_b_zero);
    assign w_fast = w_divz || w_ovf || w_mulz;

    always_comb begin
        w_fast_res = '0;
        if (w_divz) begin
            w_fast_res = bus.req_funct[1] ? bus.req_a : ONES;
        end else if (w_ovf) begin
            w_fast_res = bus.req_funct[1] ? '0 : MIN;
        end
    end
`else
    assign w_fast     = 1'b0;
    assign w_fast_res = '0;
`endif

    // Multiply: right-shifting shift-add, multiplier occupies the low half of the accumulator.
    logic [XLEN:0]       w_mul_sum;
    logic [2*XLEN-1:0]   w_mul_next;
    assign w_mul_sum  = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_b} : '0);
    assign w_mul_next = {w_mul_sum, r_acc[XLEN-1:1]};

    // Divide: restoring; high half is the partial remainder, quotient bits shift into the low half.
    logic [XLEN:0]       w_rem_sh;
    logic [XLEN:0]       w_diff;
    logic [2*XLEN-1:0]   w_div_next;
    assign w_rem_sh   = r_acc[2*XLEN-1:XLEN-1];
    assign w_diff     = w_rem_sh - {1'b0, r_b};
    assign w_div_next = w_diff[XLEN] ? {w_rem_sh[XLEN-1:0], r_acc[XLEN-2:0], 1'b0}
                                     : {w_diff[XLEN-1:0], r_acc[XLEN-2:0], 1'b1};

    logic [2*XLEN-1:0]   w_acc_next;
    logic [2*XLEN-1:0]   w_prod_fix;
    logic [XLEN-1:0]     w_quo;
    logic [XLEN-1:0]     w_rem;
    logic [XLEN-1:0]     w_final;

    assign w_acc_next = r_funct[2] ? w_div_next : w_mul_next;
    assign w_prod_fix = r_neg_q ? ('0 - w_acc_next) : w_acc_next;
    assign w_quo      = r_neg_q ? ('0 - w_acc_next[XLEN-1:0]) : w_acc_next[XLEN-1:0];
    assign w_rem      = r_neg_r ? ('0 - w_acc_next[2*XLEN-1:XLEN]) : w_acc_next[2*XLEN-1:XLEN];

    always_comb begin
        w_final = '0;
        case (r_funct)
            3'd0:                w_final = w_prod_fix[XLEN-1:0];
            3'd1, 3'd2, 3'd3:    w_final = w_prod_fix[2*XLEN-1:XLEN];
            3'd4, 3'd5:          w_final = w_quo;
            default:             w_final = w_rem;
        endcase
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_next = w_fast ? S_DONE : S_BUSY;
            S_BUSY:  if (w_last) w_next = S_DONE;
            S_DONE:  if (bus.resp_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
        if (bus.kill) begin
            w_next = S_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_count  <= '0;
            r_funct  <= '0;
            r_rd     <= '0;
            r_b      <= '0;
            r_acc    <= '0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_result <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_funct <= bus.req_funct;
                r_rd    <= bus.req_rd;
                r_b     <= w_b_mag;
                r_acc   <= {{XLEN{1'b0}}, w_a_mag};
                // A zero divisor keeps the quotient at all-ones and the remainder at the dividend.
                r_neg_q <= (w_a_neg ^ w_b_neg) && !(bus.req_funct[2] && w_b_zero);
                r_neg_r <= w_a_neg;
                r_count <= '0;
                if (w_fast) begin
                    r_result <= w_fast_res;
                end
            end else if ((r_state == S_BUSY) && !bus.kill) begin
                r_acc   <= w_acc_next;
                r_count <= r_count + 1'b1;
                if (w_last) begin
                    r_result <= w_final;
                end
            end else if (bus.kill) begin
                r_count <= '0;
            end
        end
    end

    assign bus.req_ready   = (r_state == S_IDLE);
    assign bus.resp_valid  = (r_state == S_DONE);
    assign bus.busy        = (r_state == S_BUSY) || (r_state == S_DONE);
    assign bus.resp_result = r_result;
    assign bus.resp_rd     = r_rd;
    assign o_dbg_state     = r_state;
    assign o_dbg_count     = r_count;
endmodule

// File: tb/tb_mdu_seq.sv
// Bench for mdu_seq: vector table, random ops against a reference model, and
// hand-written hold/back-to-back, kill and reset sequences.
module tb_mdu_seq;
  localparam int XLEN = 32;
  localparam int W = 37;

  typedef struct {
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  logic [1:0] dbg_state;
  logic [4:0] dbg_count;
  logic [W-1:0] exp_q[$];
  int n_cmp = 0;
  int n_fail = 0;
  int n_excl = 0;
  vec_t vecs[20];

  mdu_seq_if #(.XLEN(XLEN)) bus();

  mdu_seq #(.XLEN(XLEN)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus),
    .o_dbg_state(dbg_state),
    .o_dbg_count(dbg_count)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.resp_valid && bus.req_ready) n_excl++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ub;
    logic [63:0] p;
    logic [31:0] r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ub = longint'({32'b0, b});
    p = 64'({32'b0, a}) * 64'({32'b0, b});
    r = '0;
    case (f)
      3'd0: r = p[31:0];
      3'd1: begin p = 64'(sa * sb); r = p[63:32]; end
      3'd2: begin p = 64'(sa * ub); r = p[63:32]; end
      3'd3: r = p[63:32];
      3'd4: r = (b == 0) ? 32'hffffffff : 32'(sa / sb);
      3'd5: r = (b == 0) ? 32'hffffffff : a / b;
      3'd6: r = (b == 0) ? a : 32'(sa % sb);
      default: r = (b == 0) ? a : a % b;
    endcase
    return r;
  endfunction

  // Edges after the accept edge before resp_valid is seen.
  function automatic int exp_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
`ifdef MDU_FAST_SPECIAL_EN
    if ((f[2] && b == 0) || ((f == 3'd4 || f == 3'd6) && a == 32'h80000000 && b == 32'hffffffff) ||
        (!f[2] && (a == 0 || b == 0)))
      return 0;
`endif
    return 32;
  endfunction

  task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
    int t;
    bus.req_valid = 1'b1;
    bus.req_funct = f;
    bus.req_a = a;
    bus.req_b = b;
    bus.req_rd = rd;
    t = 0;
    while (!bus.req_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) check("issue_timeout", 32'(t), 32'd0);
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!bus.resp_valid && lat < 100) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic take_resp(input string name);
    logic [W-1:0] e;
    check({name, "_valid"}, 32'(bus.resp_valid), 32'd1);
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s_queue: got empty queue expected one entry", name);
    end else begin
      e = exp_q.pop_front();
      check({name, "_result"}, bus.resp_result, e[31:0]);
      check({name, "_rd"}, 32'(bus.resp_rd), 32'(e[36:32]));
    end
    @(posedge clk);
    @(negedge clk);
    check({name, "_handoff"}, 32'(bus.resp_valid), 32'd0);
  endtask

  task automatic run_op(input string name, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd, input logic [31:0] exp);
    int lat;
    exp_q.push_back({rd, exp});
    issue(f, a, b, rd);
    wait_valid(lat);
    check({name, "_lat"}, 32'(lat), 32'(exp_lat(f, a, b)));
    take_resp(name);
  endtask

  task automatic quiet_window(input string name);
    int seen;
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.resp_valid) seen++;
    end
    check(name, 32'(seen), 32'd0);
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_state"}, 32'(dbg_state), 32'd0);
    check({name, "_count"}, 32'(dbg_count), 32'd0);
    check({name, "_req_ready"}, 32'(bus.req_ready), 32'd1);
    check({name, "_resp_valid"}, 32'(bus.resp_valid), 32'd0);
    check({name, "_busy"}, 32'(bus.busy), 32'd0);
    check({name, "_result"}, bus.resp_result, 32'd0);
    check({name, "_rd"}, 32'(bus.resp_rd), 32'd0);
  endtask

  initial begin
    logic [W-1:0] e;
    logic [31:0] ra, rb;
    logic [2:0] rf;
    int lat, t;

    vecs[0]  = '{3'd0, 32'hffffffff, 32'hffffffff, 32'h00000001};
    vecs[1]  = '{3'd3, 32'hffffffff, 32'hffffffff, 32'hfffffffe};
    vecs[2]  = '{3'd1, 32'hffffffff, 32'hffffffff, 32'h00000000};
    vecs[3]  = '{3'd4, 32'hfffffff9, 32'h00000002, 32'hfffffffd};
    vecs[4]  = '{3'd6, 32'hfffffff9, 32'h00000002, 32'hffffffff};
    vecs[5]  = '{3'd5, 32'h00000005, 32'h00000000, 32'hffffffff};
    vecs[6]  = '{3'd7, 32'h00000005, 32'h00000000, 32'h00000005};
    vecs[7]  = '{3'd4, 32'h80000000, 32'hffffffff, 32'h80000000};
    vecs[8]  = '{3'd6, 32'h80000000, 32'hffffffff, 32'h00000000};
    vecs[9]  = '{3'd2, 32'hffffffff, 32'h00000002, 32'hffffffff};
    vecs[10] = '{3'd4, 32'h00000007, 32'h00000000, 32'hffffffff};
    vecs[11] = '{3'd6, 32'hfffffff9, 32'h00000000, 32'hfffffff9};
    vecs[12] = '{3'd0, 32'h00000000, 32'h12345678, 32'h00000000};
    vecs[13] = '{3'd1, 32'h80000000, 32'h80000000, 32'h40000000};
    vecs[14] = '{3'd5, 32'h00000100, 32'h00000007, 32'h00000024};
    vecs[15] = '{3'd7, 32'h00000100, 32'h00000007, 32'h00000004};
    vecs[16] = '{3'd2, 32'h80000000, 32'hffffffff, 32'h80000000};
    vecs[17] = '{3'd4, 32'h00000007, 32'hfffffffe, 32'hfffffffd};
    vecs[18] = '{3'd6, 32'h00000007, 32'hfffffffe, 32'h00000001};
    vecs[19] = '{3'd0, 32'h0000ffff, 32'h00010001, 32'hffffffff};

    // Clock/reset
    bus.req_valid = 1'b0;
    bus.req_funct = '0;
    bus.req_a = '0;
    bus.req_b = '0;
    bus.req_rd = '0;
    bus.resp_ready = 1'b1;
    bus.kill = 1'b0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset0");
    reset = 1'b0;

    for (int i = 0; i < 20; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].f, vecs[i].a, vecs[i].b, 5'(i), vecs[i].exp);
    end

    for (int i = 0; i < 24; i++) begin
      rf = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 5))
        0: ra = 32'h0;
        1: ra = 32'h80000000;
        2: ra = 32'hffffffff;
        default: ra = $urandom;
      endcase
      case ($urandom_range(0, 5))
        0: rb = 32'h0;
        1: rb = 32'hffffffff;
        2: rb = 32'($urandom_range(1, 9));
        default: rb = $urandom;
      endcase
      run_op($sformatf("rnd%0d", i), rf, ra, rb, 5'($urandom_range(0, 31)), ref_model(rf, ra, rb));
    end

    // Hold in DONE, then back-to-back accept one cycle after the handoff.
    bus.resp_ready = 1'b0;
    exp_q.push_back({5'd21, 32'hfffffffe});
    issue(3'd3, 32'hffffffff, 32'hffffffff, 5'd21);
    wait_valid(lat);
    check("hold_lat", 32'(lat), 32'd32);
    e = exp_q.pop_front();
    for (int i = 0; i < 10; i++) begin
      check("hold_valid", 32'(bus.resp_valid), 32'd1);
      check("hold_result", bus.resp_result, e[31:0]);
      check("hold_rd", 32'(bus.resp_rd), 32'(e[36:32]));
      check("hold_req_ready", 32'(bus.req_ready), 32'd0);
      @(negedge clk);
    end
    bus.resp_ready = 1'b1;
    bus.req_valid = 1'b1;
    bus.req_funct = 3'd5;
    bus.req_a = 32'd100;
    bus.req_b = 32'd7;
    bus.req_rd = 5'd22;
    exp_q.push_back({5'd22, 32'd14});
    @(posedge clk);
    @(negedge clk);
    check("b2b_handoff_valid", 32'(bus.resp_valid), 32'd0);
    check("b2b_handoff_ready", 32'(bus.req_ready), 32'd1);
    check("b2b_handoff_state", 32'(dbg_state), 32'd0);
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    check("b2b_accept_state", 32'(dbg_state), 32'd1);
    check("b2b_accept_busy", 32'(bus.busy), 32'd1);
    wait_valid(lat);
    check("b2b_lat", 32'(lat), 32'd32);
    take_resp("b2b");

    // Kill at count 15; the dropped op must never respond.
    issue(3'd4, 32'd1000, 32'd3, 5'd7);
    t = 0;
    while (dbg_count != 5'd15 && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("kill_reach15", 32'(dbg_count), 32'd15);
    bus.kill = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.kill = 1'b0;
    check("kill_state", 32'(dbg_state), 32'd0);
    check("kill_busy", 32'(bus.busy), 32'd0);
    check("kill_valid", 32'(bus.resp_valid), 32'd0);
    quiet_window("kill_noresp");
    run_op("after_kill", 3'd2, 32'hffffffff, 32'd2, 5'd3, 32'hffffffff);

    // kill with req_valid in IDLE must not accept.
    bus.req_valid = 1'b1;
    bus.req_funct = 3'd0;
    bus.req_a = 32'd3;
    bus.req_b = 32'd3;
    bus.kill = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.kill = 1'b0;
    check("kill_idle_state", 32'(dbg_state), 32'd0);
    check("kill_idle_busy", 32'(bus.busy), 32'd0);
    quiet_window("kill_idle_noresp");

    // Reset mid-operation.
    issue(3'd0, 32'd1234, 32'd5678, 5'd9);
    t = 0;
    while (dbg_count != 5'd10 && t < 100) begin
      @(negedge clk);
      t++;
    end
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check_reset_outputs("reset_busy");
    quiet_window("reset_noresp");
    run_op("after_reset", 3'd0, 32'd1234, 32'd5678, 5'd9, 32'd7006652);

    check("excl_violations", 32'(n_excl), 32'd0);
    check("queue_left", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
